cs_select_sequencer: RTL and testbench
======================================

// Module: cs_select_sequencer
// PURPOSE
//  Upstream driver for the 3-to-8 active-low chip-select decoder. Walks a mask of
//  8 devices in ascending index order, presenting each index on sel and holding
//  the decoder enables (d=1, e=0, f=0) for a programmable dwell.
//  Guard cycles keep the enables inactive whenever sel changes, so no decoder
//  output glitches low for a wrong device.
// PARAMETERS
//  NUM_DEV  8  devices addressed; fixed by the 3-bit decoder select, do not change
//  DWELL_W  4  width of the dwell count; each slot stays active for dwell+1 cycles
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  start      in   1        begin a sweep; sampled only in IDLE
//  dev_mask   in   8        devices to visit; bit n = decoder output n; latched on start
//  dwell      in   DWELL_W  active cycles minus 1 per slot; latched on start
//  sel        out  3        decoder select {c,b,a}; sel[0]=a, sel[2]=c
//  en_d       out  1        decoder active-high enable (d)
//  en_e_n     out  1        decoder active-low enable (e)
//  en_f_n     out  1        decoder active-low enable (f)
//  busy       out  1        high from the cycle after start until DONE is left
//  done       out  1        one-cycle pulse at end of sweep
//  abort      in   1        only with CS_SEQ_ABORT_EN; see CONFIGURATION
// BEHAVIOUR
//  - All outputs registered. Reset (and IDLE) values: sel=0, en_d=0, en_e_n=1,
//    en_f_n=1, busy=0, done=0. rst mid-sweep returns to IDLE on the next edge,
//    with enables off.
//  - States: IDLE, SETUP, ACTIVE, GAP, DONE.
//  - IDLE, start=1: latch mask and dwell. If mask!=0: go to SETUP, with sel = lowest
//    set index. If mask==0: go straight to DONE (no enable ever asserted).
//  - SETUP (1 cycle): sel stable, enables off. Next state is ACTIVE; load the dwell
//    counter with the latched dwell.
//  - ACTIVE: en_d=1, en_e_n=0, en_f_n=0. Counter decrements; when counter==0, go to GAP.
//    Time in ACTIVE is exactly dwell+1 cycles; dwell=0 gives 1 cycle.
//  - GAP (1 cycle): enables off, sel unchanged, and clear the visited mask bit.
//    If bits remain: go to SETUP with sel = next lowest set bit. Otherwise go to DONE.
//  - DONE (1 cycle): done=1, enables off. Next state is IDLE. busy drops with done.
//  - start while busy: ignored. Mask and dwell changes mid-sweep: ignored (latched copy used).
//  - Exactly one decoder output is low at a time; it is low only in ACTIVE.
//    The enables never change in the same cycle as sel.
//  - Mask 8'hFF sweeps indices 0..7. Index 7 (sel=3'b111) needs no special
//    wrap handling.
// CONFIGURATION
//  CS_SEQ_ABORT_EN defined: the abort port exists. abort=1 in any busy state
//    forces GAP-like enables-off on the next edge, then DONE, then IDLE. done
//    still pulses once. Remaining mask bits are discarded. abort in IDLE has no effect.
//  CS_SEQ_ABORT_EN undefined: no abort port; a sweep always runs to completion.
// STRUCTURE
//  cs_seq_pkg: state enum cs_seq_state_t, NUM_DEV=8, SEL_W=3, and the
//    localparams for the enable idle and active levels (d,e_n,f_n = 0,1,1 and 1,0,0).
//  Sub-module cs_lowbit_pick: combinational lowest-set-bit finder over 8 bits,
//    outputs idx[2:0] and any.
//  Top level: FSM, latched mask, dwell counter, output registers.
// TESTING
//  1. rst=1 for 2 cycles -> sel=0, en_d=0, en_e_n=en_f_n=1, busy=0, done=0.
//  2. mask=8'h01, dwell=0 -> SETUP 1 cycle, ACTIVE 1 cycle with sel=0, GAP, DONE;
//     done pulses 4 cycles after start was sampled.
//  3. mask=8'hA4, dwell=2 -> ACTIVE windows of 3 cycles each, at sel=2, 5, 7 in
//     that order. Check decoder outputs i, l, n each go low once; no overlap.
//  4. mask=8'h00 with start -> done pulses the next cycle; enables never assert.
//  5. mask=8'hFF, dwell=15; pulse start again mid-sweep and change mask -> both
//     ignored; 8 slots of 16 cycles each; busy high throughout.
//  6. rst asserted during ACTIVE of slot 3 -> enables off and IDLE on the next
//     edge; no done pulse. With CS_SEQ_ABORT_EN, repeat with abort instead of
//     rst -> enables off next edge, one done pulse, then IDLE.

Source files
------------

// File: rtl/cs_seq_pkg.sv
// Shared types and constants for the chip-select sequencer: FSM state encoding,
// device count / select width and the decoder enable levels packed as {d, e_n, f_n}.
package cs_seq_pkg;

   localparam int NUM_DEV = 8;
   localparam int SEL_W   = 3;

   localparam logic [2:0] EN_IDLE   = 3'b011;
   localparam logic [2:0] EN_ACTIVE = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACTIVE,
      ST_GAP,
      ST_DONE
   } cs_seq_state_t;

endpackage

// File: rtl/cs_lowbit_pick.sv
// Combinational lowest-set-bit finder: idx is the lowest set position of bits,
// any flags that at least one bit is set (idx is 0 when none are).
module cs_lowbit_pick
   import cs_seq_pkg::*;
(
   input  logic [NUM_DEV-1:0] bits,
   output logic [SEL_W-1:0]   idx,
   output logic               any
);

   always_comb begin
      idx = '0;
      any = 1'b0;
      // Scan downward so the last hit written is the lowest index.
      for (int i = NUM_DEV - 1; i >= 0; i--) begin
         if (bits[i]) begin
            idx = SEL_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cs_select_sequencer.sv
// Walks a latched device mask, driving the 3-to-8 decoder select and enables with
// guard cycles around every sel change. Optional abort port: define CS_SEQ_ABORT_EN.
module cs_select_sequencer
   import cs_seq_pkg::*;
#(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [NUM_DEV-1:0] dev_mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   sel,
   output logic               en_d,
   output logic               en_e_n,
   output logic               en_f_n,
   output logic               busy,
`ifdef CS_SEQ_ABORT_EN
   output logic               done,
   input  logic               abort
`else
   output logic               done
`endif
);

   cs_seq_state_t      state_q, state_d;
   logic [NUM_DEV-1:0] mask_q, mask_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0]   sel_d;
   logic [2:0]         en_lv_d;
   logic [NUM_DEV-1:0] mask_cleared;
   logic [NUM_DEV-1:0] pick_in;
   logic [SEL_W-1:0]   pick_idx;
   logic               pick_any;
   logic               abort_req;

`ifdef CS_SEQ_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // sel always holds the slot being visited, so it names the bit to retire.
   assign mask_cleared = mask_q & ~(NUM_DEV'(1) << sel);
   assign pick_in      = (state_q == ST_IDLE) ? dev_mask : mask_cleared;

   cs_lowbit_pick u_pick (
      .bits (pick_in),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      dwell_d = dwell_q;
      cnt_d   = cnt_q;
      sel_d   = sel;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mask_d  = dev_mask;
               dwell_d = dwell;
               if (pick_any) begin
                  state_d = ST_SETUP;
                  sel_d   = pick_idx;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_ACTIVE;
            cnt_d   = dwell_q;
         end
         ST_ACTIVE: begin
            if (cnt_q == '0) state_d = ST_GAP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_GAP: begin
            mask_d = mask_cleared;
            if (pick_any) begin
               state_d = ST_SETUP;
               sel_d   = pick_idx;
            end else begin
               state_d = ST_DONE;
               sel_d   = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            sel_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = '0;
         end
      endcase

      // Abort funnels through one enables-off GAP cycle; DONE is left alone so
      // the done pulse is never repeated.
      if (abort_req && (state_q == ST_SETUP || state_q == ST_ACTIVE)) begin
         state_d = ST_GAP;
         mask_d  = '0;
         sel_d   = sel;
      end else if (abort_req && state_q == ST_GAP) begin
         state_d = ST_DONE;
         mask_d  = '0;
         sel_d   = '0;
      end

      en_lv_d = (state_d == ST_ACTIVE) ? EN_ACTIVE : EN_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q                  <= ST_IDLE;
         mask_q                   <= '0;
         dwell_q                  <= '0;
         cnt_q                    <= '0;
         sel                      <= '0;
         {en_d, en_e_n, en_f_n}   <= EN_IDLE;
         busy                     <= 1'b0;
         done                     <= 1'b0;
      end else begin
         state_q                  <= state_d;
         mask_q                   <= mask_d;
         dwell_q                  <= dwell_d;
         cnt_q                    <= cnt_d;
         sel                      <= sel_d;
         {en_d, en_e_n, en_f_n}   <= en_lv_d;
         busy                     <= (state_d != ST_IDLE);
         done                     <= (state_d == ST_DONE);
      end
   end

endmodule

// File: tb/tb_cs_select_sequencer.sv
// Directed bench for cs_select_sequencer: per-cycle expected output vectors are
// queued from each sweep's mask/dwell and compared one clock edge at a time.
module tb_cs_select_sequencer;

   localparam logic [2:0] EN_OFF = 3'b011;
   localparam logic [2:0] EN_ON  = 3'b100;

   typedef struct packed {
      logic [2:0] sel;
      logic       sel_care;
      logic [2:0] en;
      logic       busy;
      logic       done;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] dev_mask;
   logic [3:0] dwell;
   logic [2:0] sel;
   logic       en_d, en_e_n, en_f_n;
   logic       busy, done;
`ifdef CS_SEQ_ABORT_EN
   logic       abort;
`endif

   exp_t       sbq[$];
   int         n_vec;
   int         n_err;
   string      tag;
   int         lowcnt[8];
   int         pulses[8];
   logic [7:0] prev_y;
   logic [2:0] prev_sel;
   logic [2:0] prev_en;
   logic       prev_valid;

   cs_select_sequencer #(.DWELL_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dev_mask (dev_mask),
      .dwell    (dwell),
      .sel      (sel),
      .en_d     (en_d),
      .en_e_n   (en_e_n),
      .en_f_n   (en_f_n),
      .busy     (busy),
`ifdef CS_SEQ_ABORT_EN
      .done     (done),
      .abort    (abort)
`else
      .done     (done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] decode(input logic [2:0] s, input logic [2:0] en);
      logic [7:0] one;
      one = 8'b1;
      if (en == EN_ON) return ~(one << s);
      return 8'hFF;
   endfunction

   task automatic push_vec(input logic [2:0] s, input logic care, input logic [2:0] en,
                           input logic b, input logic d);
      exp_t e;
      e.sel = s; e.sel_care = care; e.en = en; e.busy = b; e.done = d;
      sbq.push_back(e);
   endtask

   task automatic push_idle();
      push_vec(3'd0, 1'b1, EN_OFF, 1'b0, 1'b0);
   endtask

   // Expected trace of a full sweep, one entry per clock edge from the start edge on.
   task automatic push_trace(input logic [7:0] m, input logic [3:0] w);
      if (m != 8'h00) begin
         for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
               push_vec(3'(i), 1'b1, EN_OFF, 1'b1, 1'b0);
               for (int k = 0; k <= int'(w); k++) push_vec(3'(i), 1'b1, EN_ON, 1'b1, 1'b0);
               push_vec(3'(i), 1'b1, EN_OFF, 1'b1, 1'b0);
            end
         end
      end
      push_vec(3'd0, 1'b0, EN_OFF, 1'b1, 1'b1);
      push_idle();
   endtask

   task automatic clear_dec();
      for (int i = 0; i < 8; i++) begin
         lowcnt[i] = 0;
         pulses[i] = 0;
      end
   endtask

   task automatic step();
      exp_t       e;
      logic       rst_at_edge;
      logic [7:0] y;
      logic [2:0] en_now;
      rst_at_edge = rst;
      @(posedge clk);
      #1;
      en_now = {en_d, en_e_n, en_f_n};
      if (sbq.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: output appeared with no expected vector queued", tag);
      end else begin
         e = sbq.pop_front();
         n_vec++;
         assert (en_now === e.en && busy === e.busy && done === e.done &&
                 (!e.sel_care || sel === e.sel))
         else begin
            n_err++;
            $error("FAIL %s: got sel=%0d en=%b busy=%b done=%b, want sel=%0d(care=%b) en=%b busy=%b done=%b",
                   tag, sel, en_now, busy, done, e.sel, e.sel_care, e.en, e.busy, e.done);
         end
      end
      if (prev_valid && !rst_at_edge) begin
         n_vec++;
         assert (!((sel !== prev_sel) && (en_now !== prev_en)))
         else begin
            n_err++;
            $error("FAIL %s_guard: sel %0d->%0d and en %b->%b on the same edge",
                   tag, prev_sel, sel, prev_en, en_now);
         end
      end
      y = decode(sel, en_now);
      for (int i = 0; i < 8; i++) begin
         if (!y[i]) lowcnt[i]++;
         if (!y[i] && prev_y[i]) pulses[i]++;
      end
      prev_y     = y;
      prev_sel   = sel;
      prev_en    = en_now;
      prev_valid = 1'b1;
   endtask

   task automatic sweep(input logic [7:0] m, input logic [3:0] w, input int perturb_at);
      dev_mask = m;
      dwell    = w;
      start    = 1'b1;
      push_trace(m, w);
      step();
      start = 1'b0;
      for (int n = 1; n < 400 && sbq.size() > 0; n++) begin
         if (n == perturb_at) begin
            start    = 1'b1;
            dev_mask = ~m;
            dwell    = w ^ 4'h5;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
   endtask

   // Run a sweep for 'cut' edges, then interrupt it with rst (or abort).
   task automatic sweep_cut(input logic [7:0] m, input logic [3:0] w, input int cut,
                            input logic [2:0] cur_sel, input logic use_abort);
      dev_mask = m;
      dwell    = w;
      start    = 1'b1;
      push_trace(m, w);
      step();
      start = 1'b0;
      for (int n = 1; n < cut; n++) step();
      sbq.delete();
      if (!use_abort) begin
         rst = 1'b1;
         push_idle();
         step();
         rst = 1'b0;
         repeat (3) push_idle();
         repeat (3) step();
      end else begin
`ifdef CS_SEQ_ABORT_EN
         abort = 1'b1;
         push_vec(cur_sel, 1'b1, EN_OFF, 1'b1, 1'b0);
         step();
         abort = 1'b0;
         push_vec(3'd0, 1'b0, EN_OFF, 1'b1, 1'b1);
         repeat (2) push_idle();
         repeat (3) step();
`else
         push_vec(cur_sel, 1'b1, EN_OFF, 1'b1, 1'b0);
         step();
`endif
      end
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      prev_valid = 1'b0;
      prev_y     = 8'hFF;
      prev_sel   = 3'd0;
      prev_en    = EN_OFF;
      rst        = 1'b1;
      start      = 1'b0;
      dev_mask   = 8'h00;
      dwell      = 4'd0;
`ifdef CS_SEQ_ABORT_EN
      abort      = 1'b0;
`endif
      clear_dec();

      tag = "reset";
      repeat (2) push_idle();
      repeat (2) step();
      rst = 1'b0;
      push_idle();
      step();

      tag = "mask01_dw0";
      sweep(8'h01, 4'd0, -1);

      tag = "maskA4_dw2";
      clear_dec();
      sweep(8'hA4, 4'd2, -1);
      for (int i = 0; i < 8; i++) begin
         int want_p;
         want_p = (i == 2 || i == 5 || i == 7) ? 1 : 0;
         n_vec++;
         assert (pulses[i] == want_p && lowcnt[i] == 3 * want_p)
         else begin
            n_err++;
            $error("FAIL dec_y%0d: got pulses=%0d low_cycles=%0d, want pulses=%0d low_cycles=%0d",
                   i, pulses[i], lowcnt[i], want_p, 3 * want_p);
         end
      end

      tag = "mask00";
      clear_dec();
      sweep(8'h00, 4'd5, -1);
      n_vec++;
      assert (pulses.sum() == 0)
      else begin
         n_err++;
         $error("FAIL mask00_dec: got %0d decoder pulses, want 0", pulses.sum());
      end

      tag = "mask80_dw1";
      sweep(8'h80, 4'd1, -1);

      tag = "mask81_dw0";
      sweep(8'h81, 4'd0, -1);

      tag = "maskFF_dw15";
      sweep(8'hFF, 4'd15, 30);

      tag = "rst_mid";
      sweep_cut(8'hFF, 4'd3, 21, 3'd3, 1'b0);

`ifdef CS_SEQ_ABORT_EN
      tag = "abort_mid";
      sweep_cut(8'hFF, 4'd3, 21, 3'd3, 1'b1);

      tag = "abort_idle";
      abort = 1'b1;
      repeat (2) push_idle();
      repeat (2) step();
      abort = 1'b0;
`endif

      tag = "after";
      sweep(8'h10, 4'd0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
